// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared core definitions for the multicycle controller.
//               Contains the controller state encoding, the default reset
//               PC and the canonical NOP instruction (ADDI x0, x0, 0).
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

    // Controller sequencing states, one instruction walks through them in order
    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        MEM_REQ    = 3'd3,
        MEM_WAIT   = 3'd4
    } state_t;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    // A load and a store flagged together still cost only one data access
    function automatic logic is_mem_op(input logic is_load, input logic is_store);
        return is_load | is_store;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_npc_sel.sv
`default_nettype none
// ============================================================================
// Module      : npc_sel
// Description : Combinational next-PC selector. Priority, highest first:
//               exception entry, exception return, taken branch, pc + 4.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_sel
    import multicycle_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            ex_i,
    input  logic [XLEN-1:0] ex_entry_i,
    input  logic            ex_ret_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    output logic [XLEN-1:0] next_pc_o
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // Priority mux; the sequential fall-through wraps naturally at 2^XLEN
    always_comb begin
        next_pc_o = pc_i + PC_STEP;
        if (ex_i) begin
            next_pc_o = ex_entry_i;
        end else if (ex_ret_i) begin
            next_pc_o = epc_i;
        end else if (br_taken_i) begin
            next_pc_o = br_target_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle instruction sequencer. Fetches one instruction,
//               executes it, optionally performs a single data access, then
//               retires it with a one-cycle commit strobe.
//               Optional macro MULTICYCLE_PERF_CNT_EN adds 64-bit cycle and
//               retired-instruction counters as extra outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    input  logic            dmem_rsp_valid,
    input  logic            dec_is_load,
    input  logic            dec_is_store,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            ex,
    input  logic [XLEN-1:0] ex_entry,
    input  logic            ex_ret,
    input  logic [XLEN-1:0] epc,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic            commit
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt
`endif
);

    localparam logic [XLEN-1:0] PC_RESET_VAL = RESET_PC[XLEN-1:0];

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [XLEN-1:0]   w_next_pc;
    logic              w_commit;
    logic              w_imem_req_valid;
    logic              w_dmem_req_valid;

    npc_sel #(
        .XLEN        (XLEN)
    ) u_npc_sel (
        .pc_i        (pc_q),
        .ex_i        (ex),
        .ex_entry_i  (ex_entry),
        .ex_ret_i    (ex_ret),
        .epc_i       (epc),
        .br_taken_i  (br_taken),
        .br_target_i (br_target),
        .next_pc_o   (w_next_pc)
    );

    // State, PC and instruction registers; reset abandons any open handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FETCH_REQ;
            pc_q    <= PC_RESET_VAL;
            inst_q  <= NOP_INST;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    // Next-state, request strobes and commit; PC only moves on the commit cycle
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        inst_d           = inst_q;
        w_commit         = 1'b0;
        w_imem_req_valid = 1'b0;
        w_dmem_req_valid = 1'b0;
        case (state_q)
            FETCH_REQ: begin
                w_imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_d  = imem_rsp_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_mem_op(dec_is_load, dec_is_store)) begin
                    state_d = MEM_REQ;
                end else begin
                    w_commit = 1'b1;
                    pc_d     = w_next_pc;
                    state_d  = FETCH_REQ;
                end
            end
            MEM_REQ: begin
                w_dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_rsp_valid) begin
                    w_commit = 1'b1;
                    pc_d     = w_next_pc;
                    state_d  = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase
    end

    // Strobes are masked while reset is held so nothing leaks out mid-reset
    assign imem_req_valid = w_imem_req_valid & rst;
    assign dmem_req_valid = w_dmem_req_valid & rst;
    assign commit         = w_commit & rst;
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign next_pc        = w_next_pc;
    assign inst           = inst_q;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [63:0] cycle_cnt_q;
    logic [63:0] instret_cnt_q;

    // Free-running cycle count and retired-instruction count, both wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt_q   <= 64'd0;
            instret_cnt_q <= 64'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 64'd1;
            if (w_commit) begin
                instret_cnt_q <= instret_cnt_q + 64'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule
`default_nettype wire
